// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg
//   Shared types and default constants for the receive bit timer.
//   rx_timer_state_t : timer FSM states (IDLE, ARMED, RUN)
//   RX_*             : default parameter values used by rx_bit_timer
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } rx_timer_state_t;

  localparam int RX_CLKS_PER_BIT  = 8;
  localparam int RX_SAMPLE_POINT  = 3;
  localparam int RX_BITS_PER_BYTE = 8;

endpackage

// File: rtl/flex_counter.sv
// flex_counter
//   Parameterised rollover counter. After a clear the count is 0; each
//   enabled cycle advances it through 1..rollover_val, wrapping from
//   rollover_val back to 1. rollover_flag is a registered one-cycle pulse
//   in the cycle after the count reaches rollover_val.
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear          : synchronous clear (wins over count_enable)
//   count_enable   : advance the count this cycle
//   rollover_val   : terminal count (must be >= 2)
//   count_out      : current count
//   rollover_flag  : one-cycle pulse after reaching rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_nxt_s;
  logic                    flag_nxt_s;

  // Next count and next rollover pulse.
  always_comb begin
    count_nxt_s = count_out;
    flag_nxt_s  = 1'b0;
    if (clear) begin
      count_nxt_s = '0;
      flag_nxt_s  = 1'b0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_nxt_s = NUM_CNT_BITS'(1);
      end else begin
        count_nxt_s = count_out + NUM_CNT_BITS'(1);
      end
      // This increment lands on the terminal count.
      flag_nxt_s = (count_out == (rollover_val - NUM_CNT_BITS'(1)));
    end else begin
      count_nxt_s = count_out;
      flag_nxt_s  = 1'b0;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= count_nxt_s;
      rollover_flag <= flag_nxt_s;
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer
//   Recovers bit boundaries on an oversampled serial line. A phase counter
//   runs modulo CLKS_PER_BIT and is reloaded to 1 on every data edge (the
//   edge cycle is phase 0). shift_strobe fires at SAMPLE_POINT of each bit;
//   byte_received pulses after every BITS_PER_BYTE strobes.
//   clk, n_rst    : clock, asynchronous active-low reset
//   enable_timer  : level, high while packet data is expected
//   d_edge        : one-cycle pulse on a serial line transition
//   shift_strobe  : sample the line this cycle
//   byte_received : registered one-cycle pulse, byte complete
//   bit_count     : strobes seen in the current byte (0..BITS_PER_BYTE-1)
//   timer_active  : high while in RUN
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT,
  parameter int SAMPLE_POINT  = RX_SAMPLE_POINT,
  parameter int BITS_PER_BYTE = RX_BITS_PER_BYTE
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  output logic       shift_strobe,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       timer_active
);

  localparam logic [3:0] PH_LAST   = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] PH_SAMPLE = 4'(SAMPLE_POINT);
  localparam logic [3:0] BYTE_LEN  = 4'(BITS_PER_BYTE);

  rx_timer_state_t state_r;
  rx_timer_state_t state_nxt_s;
  logic [3:0]      ph_r;
  logic [3:0]      ph_nxt_s;
  logic [3:0]      cnt_s;

  // Next state and next phase; enable_timer low beats d_edge beats advance.
  always_comb begin
    state_nxt_s = state_r;
    ph_nxt_s    = ph_r;
    case (state_r)
      IDLE: begin
        ph_nxt_s = 4'd0;
        if (enable_timer) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (!enable_timer) begin
          state_nxt_s = IDLE;
          ph_nxt_s    = 4'd0;
        end else if (d_edge) begin
          // The edge cycle itself is phase 0.
          state_nxt_s = RUN;
          ph_nxt_s    = 4'd1;
        end else begin
          state_nxt_s = ARMED;
          ph_nxt_s    = 4'd0;
        end
      end
      RUN: begin
        if (!enable_timer) begin
          state_nxt_s = IDLE;
          ph_nxt_s    = 4'd0;
        end else if (d_edge) begin
          state_nxt_s = RUN;
          ph_nxt_s    = 4'd1;
        end else if (ph_r == PH_LAST) begin
          state_nxt_s = RUN;
          ph_nxt_s    = 4'd0;
        end else begin
          state_nxt_s = RUN;
          ph_nxt_s    = ph_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ph_nxt_s    = 4'd0;
      end
    endcase
  end

  // State and phase registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      ph_r    <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      ph_r    <= ph_nxt_s;
    end
  end

  // Decoded from registers only, so no input-to-output path.
  assign shift_strobe = (state_r == RUN) && (ph_r == PH_SAMPLE);
  assign timer_active = (state_r == RUN);

  // Bit counter: clearing on enable_timer low keeps a strobe in the
  // disable cycle from counting or producing a byte pulse.
  flex_counter #(
    .NUM_CNT_BITS (4)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (~enable_timer),
    .count_enable  (shift_strobe),
    .rollover_val  (BYTE_LEN),
    .count_out     (cnt_s),
    .rollover_flag (byte_received)
  );

  // Counter holds 1..N; a full byte (N) reads as 0 strobes into the next.
  assign bit_count = (cnt_s == BYTE_LEN) ? 4'd0 : cnt_s;

endmodule
